// File: rtl/control_unit.sv
// Hardwired Moore control sequencer: fetch in T0-T2, opcode-specific execute steps in
// T3-T7, then back to T0 (or HALT on Stop/halt). Strobes are registered per state.
module control_unit #(
  parameter int unsigned    OPW    = 5,
  parameter logic [OPW-1:0] ADD_OP = 5'b00011
) (
  input  logic           i_Clock,
  input  logic           i_Clear,
  input  logic [31:0]    i_IR,
  input  logic           i_CON_FF,
  input  logic           i_Stop,
  output logic           o_Run,
  output logic           o_PCout,
  output logic           o_Zhighout,
  output logic           o_Zlowout,
  output logic           o_MDRout,
  output logic           o_HIout,
  output logic           o_LOout,
  output logic           o_BAout,
  output logic           o_Cout,
  output logic           o_Rout,
  output logic           o_PCin,
  output logic           o_MARin,
  output logic           o_MDRin,
  output logic           o_IRin,
  output logic           o_Yin,
  output logic           o_Zin,
  output logic           o_HIin,
  output logic           o_LOin,
  output logic           o_Rin,
  output logic           o_CONin,
  output logic           o_Gra,
  output logic           o_Grb,
  output logic           o_Grc,
  output logic           o_IncPC,
  output logic           o_Read,
  output logic           o_Write,
  output logic [OPW-1:0] o_alu_op
);

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_NOP, C_HALT, C_RALU, C_NEGNOT, C_IMM, C_LDI, C_LD, C_ST,
    C_MULDIV, C_MFHI, C_MFLO, C_JR, C_BRX
  } class_t;

  typedef struct packed {
    logic           run;
    logic           pcOut, zHighOut, zLowOut, mdrOut, hiOut, loOut, baOut, cOut, rOut;
    logic           pcIn, marIn, mdrIn, irIn, yIn, zIn, hiIn, loIn, rIn, conIn;
    logic           gra, grb, grc;
    logic           incPc, read, write;
    logic [OPW-1:0] aluOp;
  } strobes_t;

  state_t         r_state;
  logic [OPW-1:0] r_opcode;
  strobes_t       r_out;
  logic           r_brxPc;

  state_t         w_nextState;
  state_t         w_boundary;
  logic [OPW-1:0] w_nextOp;
  logic [OPW-1:0] w_irOp;
  logic           w_execDone;
  logic           w_unusedIr;

  assign w_irOp     = i_IR[31 -: OPW];
  assign w_unusedIr = ^i_IR[31-OPW:0];

  function automatic class_t opClass(input logic [OPW-1:0] op);
    class_t c;
    case (32'(op))
      0:                          c = C_LD;
      1:                          c = C_LDI;
      2:                          c = C_ST;
      3, 4, 5, 6, 7, 8, 9, 10, 11: c = C_RALU;
      12, 13, 14:                 c = C_IMM;
      15, 16:                     c = C_MULDIV;
      17, 18:                     c = C_NEGNOT;
      19:                         c = C_BRX;
      20:                         c = C_JR;
      24:                         c = C_MFHI;
      25:                         c = C_MFLO;
      27:                         c = C_HALT;
      default:                    c = C_NOP;
    endcase
    return c;
  endfunction

  // Number of execute steps (T3 onward) each instruction class occupies.
  function automatic logic [2:0] stepCount(input class_t c);
    logic [2:0] n;
    case (c)
      C_MFHI, C_MFLO, C_JR:  n = 3'd1;
      C_NEGNOT:              n = 3'd2;
      C_RALU, C_IMM, C_LDI:  n = 3'd3;
      C_MULDIV, C_BRX:       n = 3'd4;
      C_LD, C_ST:            n = 3'd5;
      default:               n = 3'd0;
    endcase
    return n;
  endfunction

  function automatic logic [2:0] execIdx(input state_t st);
    logic [2:0] k;
    case (st)
      S_T3:    k = 3'd1;
      S_T4:    k = 3'd2;
      S_T5:    k = 3'd3;
      S_T6:    k = 3'd4;
      S_T7:    k = 3'd5;
      default: k = 3'd0;
    endcase
    return k;
  endfunction

  function automatic strobes_t decode(input state_t st, input logic [OPW-1:0] op);
    strobes_t s;
    class_t   c;
    s     = '0;
    c     = opClass(op);
    s.run = (st != S_RESET) && (st != S_HALT);
    case (st)
      S_T0: begin s.pcOut = 1'b1; s.marIn = 1'b1; s.incPc = 1'b1; s.zIn = 1'b1; end
      S_T1: begin s.zLowOut = 1'b1; s.pcIn = 1'b1; s.read = 1'b1; s.mdrIn = 1'b1; end
      S_T2: begin s.mdrOut = 1'b1; s.irIn = 1'b1; end
      S_T3: begin
        case (c)
          C_RALU, C_IMM:      begin s.grb = 1'b1; s.rOut = 1'b1; s.yIn = 1'b1; end
          C_LDI, C_LD, C_ST:  begin s.grb = 1'b1; s.baOut = 1'b1; s.yIn = 1'b1; end
          C_NEGNOT:           begin s.grb = 1'b1; s.rOut = 1'b1; s.zIn = 1'b1; s.aluOp = op; end
          C_MULDIV:           begin s.gra = 1'b1; s.rOut = 1'b1; s.yIn = 1'b1; end
          C_MFHI:             begin s.hiOut = 1'b1; s.gra = 1'b1; s.rIn = 1'b1; end
          C_MFLO:             begin s.loOut = 1'b1; s.gra = 1'b1; s.rIn = 1'b1; end
          C_JR:               begin s.gra = 1'b1; s.rOut = 1'b1; s.pcIn = 1'b1; end
          C_BRX:              begin s.gra = 1'b1; s.rOut = 1'b1; s.conIn = 1'b1; end
          default: ;
        endcase
      end
      S_T4: begin
        case (c)
          C_RALU:             begin s.grc = 1'b1; s.rOut = 1'b1; s.zIn = 1'b1; s.aluOp = op; end
          C_IMM:              begin s.cOut = 1'b1; s.zIn = 1'b1; s.aluOp = op; end
          C_LDI, C_LD, C_ST:  begin s.cOut = 1'b1; s.zIn = 1'b1; s.aluOp = ADD_OP; end
          C_NEGNOT:           begin s.zLowOut = 1'b1; s.gra = 1'b1; s.rIn = 1'b1; end
          C_MULDIV:           begin s.grb = 1'b1; s.rOut = 1'b1; s.zIn = 1'b1; s.aluOp = op; end
          C_BRX:              begin s.pcOut = 1'b1; s.yIn = 1'b1; end
          default: ;
        endcase
      end
      S_T5: begin
        case (c)
          C_RALU, C_IMM, C_LDI: begin s.zLowOut = 1'b1; s.gra = 1'b1; s.rIn = 1'b1; end
          C_LD, C_ST:           begin s.zLowOut = 1'b1; s.marIn = 1'b1; end
          C_MULDIV:             begin s.zLowOut = 1'b1; s.loIn = 1'b1; end
          C_BRX:                begin s.cOut = 1'b1; s.zIn = 1'b1; s.aluOp = ADD_OP; end
          default: ;
        endcase
      end
      S_T6: begin
        case (c)
          C_LD:     begin s.read = 1'b1; s.mdrIn = 1'b1; end
          C_ST:     begin s.gra = 1'b1; s.rOut = 1'b1; s.mdrIn = 1'b1; end
          C_MULDIV: begin s.zHighOut = 1'b1; s.hiIn = 1'b1; end
          C_BRX:    s.zLowOut = 1'b1;
          default: ;
        endcase
      end
      S_T7: begin
        case (c)
          C_LD:    begin s.mdrOut = 1'b1; s.gra = 1'b1; s.rIn = 1'b1; end
          C_ST:    s.write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
    return s;
  endfunction

  // Next-state selection; the opcode is taken live from IR only while leaving T2.
  always_comb begin
    w_nextOp    = (r_state == S_T2) ? w_irOp : r_opcode;
    w_boundary  = i_Stop ? S_HALT : S_T0;
    w_execDone  = execIdx(r_state) >= stepCount(opClass(r_opcode));
    w_nextState = r_state;
    case (r_state)
      S_RESET: w_nextState = S_T0;
      S_T0:    w_nextState = S_T1;
      S_T1:    w_nextState = S_T2;
      S_T2: begin
        if (opClass(w_irOp) == C_HALT)     w_nextState = S_HALT;
        else if (opClass(w_irOp) == C_NOP) w_nextState = w_boundary;
        else                               w_nextState = S_T3;
      end
      S_T3:    w_nextState = w_execDone ? w_boundary : S_T4;
      S_T4:    w_nextState = w_execDone ? w_boundary : S_T5;
      S_T5:    w_nextState = w_execDone ? w_boundary : S_T6;
      S_T6:    w_nextState = w_execDone ? w_boundary : S_T7;
      S_T7:    w_nextState = w_boundary;
      S_HALT:  w_nextState = S_HALT;
      default: w_nextState = S_RESET;
    endcase
  end

  // State, latched opcode and the strobes for the state being entered.
  always_ff @(posedge i_Clock or posedge i_Clear) begin
    if (i_Clear) begin
      r_state  <= S_RESET;
      r_opcode <= '0;
      r_out    <= '0;
      r_brxPc  <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_opcode <= w_nextOp;
      r_out    <= decode(w_nextState, w_nextOp);
      r_brxPc  <= (w_nextState == S_T6) && (opClass(w_nextOp) == C_BRX);
    end
  end

  assign o_Run      = r_out.run;
  assign o_PCout    = r_out.pcOut;
  assign o_Zhighout = r_out.zHighOut;
  assign o_Zlowout  = r_out.zLowOut;
  assign o_MDRout   = r_out.mdrOut;
  assign o_HIout    = r_out.hiOut;
  assign o_LOout    = r_out.loOut;
  assign o_BAout    = r_out.baOut;
  assign o_Cout     = r_out.cOut;
  assign o_Rout     = r_out.rOut;
  // The branch condition must be seen live during T6, not at the edge entering it.
  assign o_PCin     = r_out.pcIn | (r_brxPc & i_CON_FF);
  assign o_MARin    = r_out.marIn;
  assign o_MDRin    = r_out.mdrIn;
  assign o_IRin     = r_out.irIn;
  assign o_Yin      = r_out.yIn;
  assign o_Zin      = r_out.zIn;
  assign o_HIin     = r_out.hiIn;
  assign o_LOin     = r_out.loIn;
  assign o_Rin      = r_out.rIn;
  assign o_CONin    = r_out.conIn;
  assign o_Gra      = r_out.gra;
  assign o_Grb      = r_out.grb;
  assign o_Grc      = r_out.grc;
  assign o_IncPC    = r_out.incPc;
  assign o_Read     = r_out.read;
  assign o_Write    = r_out.write;
  assign o_alu_op   = r_out.aluOp;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: a queue-of-cycles instruction model checked every cycle,
// plus directed sequences with hand-written expectations.
`timescale 1ns/1ps
module tb_control_unit;

  localparam int B_RUN = 0, B_PCOUT = 1, B_ZHI = 2, B_ZLO = 3, B_MDROUT = 4, B_HIOUT = 5,
    B_LOOUT = 6, B_BAOUT = 7, B_COUT = 8, B_ROUT = 9, B_PCIN = 10, B_MARIN = 11,
    B_MDRIN = 12, B_IRIN = 13, B_YIN = 14, B_ZIN = 15, B_HIIN = 16, B_LOIN = 17,
    B_RIN = 18, B_CONIN = 19, B_GRA = 20, B_GRB = 21, B_GRC = 22, B_INCPC = 23,
    B_READ = 24, B_WRITE = 25, B_CONPC = 31;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] ir = 32'h0;
  logic        conFf = 1'b0;
  logic        stop = 1'b0;
  logic        run, pcOut, zHighOut, zLowOut, mdrOut, hiOut, loOut, baOut, cOut, rOut;
  logic        pcIn, marIn, mdrIn, irIn, yIn, zIn, hiIn, loIn, rIn, conIn;
  logic        gra, grb, grc, incPc, read, write;
  logic [4:0]  aluOp;
  logic [31:0] dutVec;
  logic [31:0] expVec;

  typedef enum {M_RESET, M_RUN, M_HALT} mode_t;
  mode_t       mMode = M_RESET;
  logic [31:0] mQ[$];
  int          mPos = 0;
  int          checks = 0;
  int          failures = 0;
  bit          randCon = 1'b1;

  always #5 clock = ~clock;

  control_unit dut (
    .i_Clock(clock), .i_Clear(clear), .i_IR(ir), .i_CON_FF(conFf), .i_Stop(stop),
    .o_Run(run), .o_PCout(pcOut), .o_Zhighout(zHighOut), .o_Zlowout(zLowOut),
    .o_MDRout(mdrOut), .o_HIout(hiOut), .o_LOout(loOut), .o_BAout(baOut), .o_Cout(cOut),
    .o_Rout(rOut), .o_PCin(pcIn), .o_MARin(marIn), .o_MDRin(mdrIn), .o_IRin(irIn),
    .o_Yin(yIn), .o_Zin(zIn), .o_HIin(hiIn), .o_LOin(loIn), .o_Rin(rIn), .o_CONin(conIn),
    .o_Gra(gra), .o_Grb(grb), .o_Grc(grc), .o_IncPC(incPc), .o_Read(read), .o_Write(write),
    .o_alu_op(aluOp)
  );

  assign dutVec = {1'b0, aluOp, write, read, incPc, grc, grb, gra, conIn, rIn, loIn, hiIn,
                   zIn, yIn, irIn, mdrIn, marIn, pcIn, rOut, cOut, baOut, loOut, hiOut,
                   mdrOut, zLowOut, zHighOut, pcOut, run};

  function automatic logic [31:0] b(input int i);
    return 32'd1 << i;
  endfunction

  task automatic pushStep(input logic [31:0] v, input logic [4:0] alu);
    mQ.push_back(v | b(B_RUN) | (32'(alu) << 26));
  endtask

  task automatic pushFetch();
    pushStep(b(B_PCOUT) | b(B_MARIN) | b(B_INCPC) | b(B_ZIN), 5'd0);
    pushStep(b(B_ZLO) | b(B_PCIN) | b(B_READ) | b(B_MDRIN), 5'd0);
    pushStep(b(B_MDROUT) | b(B_IRIN), 5'd0);
  endtask

  // Execute-phase cycles of one instruction, written straight from its step list.
  task automatic pushExec(input logic [4:0] op);
    case (int'(op))
      3, 4, 5, 6, 7, 8, 9, 10, 11: begin
        pushStep(b(B_GRB) | b(B_ROUT) | b(B_YIN), 5'd0);
        pushStep(b(B_GRC) | b(B_ROUT) | b(B_ZIN), op);
        pushStep(b(B_ZLO) | b(B_GRA) | b(B_RIN), 5'd0);
      end
      17, 18: begin
        pushStep(b(B_GRB) | b(B_ROUT) | b(B_ZIN), op);
        pushStep(b(B_ZLO) | b(B_GRA) | b(B_RIN), 5'd0);
      end
      12, 13, 14: begin
        pushStep(b(B_GRB) | b(B_ROUT) | b(B_YIN), 5'd0);
        pushStep(b(B_COUT) | b(B_ZIN), op);
        pushStep(b(B_ZLO) | b(B_GRA) | b(B_RIN), 5'd0);
      end
      1: begin
        pushStep(b(B_GRB) | b(B_BAOUT) | b(B_YIN), 5'd0);
        pushStep(b(B_COUT) | b(B_ZIN), 5'd3);
        pushStep(b(B_ZLO) | b(B_GRA) | b(B_RIN), 5'd0);
      end
      0, 2: begin
        pushStep(b(B_GRB) | b(B_BAOUT) | b(B_YIN), 5'd0);
        pushStep(b(B_COUT) | b(B_ZIN), 5'd3);
        pushStep(b(B_ZLO) | b(B_MARIN), 5'd0);
        if (op == 5'd0) begin
          pushStep(b(B_READ) | b(B_MDRIN), 5'd0);
          pushStep(b(B_MDROUT) | b(B_GRA) | b(B_RIN), 5'd0);
        end else begin
          pushStep(b(B_GRA) | b(B_ROUT) | b(B_MDRIN), 5'd0);
          pushStep(b(B_WRITE), 5'd0);
        end
      end
      15, 16: begin
        pushStep(b(B_GRA) | b(B_ROUT) | b(B_YIN), 5'd0);
        pushStep(b(B_GRB) | b(B_ROUT) | b(B_ZIN), op);
        pushStep(b(B_ZLO) | b(B_LOIN), 5'd0);
        pushStep(b(B_ZHI) | b(B_HIIN), 5'd0);
      end
      24: pushStep(b(B_HIOUT) | b(B_GRA) | b(B_RIN), 5'd0);
      25: pushStep(b(B_LOOUT) | b(B_GRA) | b(B_RIN), 5'd0);
      20: pushStep(b(B_GRA) | b(B_ROUT) | b(B_PCIN), 5'd0);
      19: begin
        pushStep(b(B_GRA) | b(B_ROUT) | b(B_CONIN), 5'd0);
        pushStep(b(B_PCOUT) | b(B_YIN), 5'd0);
        pushStep(b(B_COUT) | b(B_ZIN), 5'd3);
        pushStep(b(B_ZLO) | b(B_CONPC), 5'd0);
      end
      default: ;
    endcase
  endtask

  // Reference model: one queue entry per upcoming cycle, head is the current cycle.
  always @(posedge clock or posedge clear) begin
    if (clear) begin
      mMode = M_RESET;
      mQ.delete();
      mPos = 0;
    end else begin
      case (mMode)
        M_RESET: begin
          mMode = M_RUN;
          pushFetch();
          mPos = 0;
        end
        M_RUN: begin
          if (mQ.size() > 0) void'(mQ.pop_front());
          mPos++;
          if (mPos == 3) begin
            if (ir[31:27] == 5'd27) mMode = M_HALT;
            else pushExec(ir[31:27]);
          end
          if (mMode == M_RUN && mQ.size() == 0) begin
            if (stop) mMode = M_HALT;
            else begin
              pushFetch();
              mPos = 0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, actual, expected);
    end
  endtask

  always @(negedge clock) begin
    expVec = 32'h0;
    if (mMode == M_RUN && mQ.size() > 0) begin
      expVec = mQ[0];
      if (expVec[B_CONPC]) begin
        expVec[B_PCIN]  = conFf;
        expVec[B_CONPC] = 1'b0;
      end
    end
    checkOutput("cycle strobes", dutVec, expVec);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clock);
      #1;
      if (randCon) conFf = 1'($urandom_range(0, 1));
    end
  endtask

  // Clear asserted mid-cycle, held across one edge, then released; ends showing T0.
  task automatic restart();
    clear = 1'b1;
    #1;
    checkOutput("clear immediate zero", dutVec, 32'h0);
    tick(1);
    clear = 1'b0;
    tick(1);
    checkOutput("restart run", 32'(run), 32'd1);
    checkOutput("restart T0 IncPC", 32'(incPc), 32'd1);
  endtask

  // Runs one instruction starting from a displayed T0 until the next boundary.
  task automatic applyStimulus(input logic [31:0] irVal, input logic stopVal,
                               input logic pulseStop);
    bit done;
    done = 1'b0;
    ir   = irVal;
    stop = stopVal;
    for (int i = 0; i < 16 && !done; i++) begin
      tick(1);
      if (mMode != M_RUN || mPos == 0) done = 1'b1;
      else if (mPos == 3) begin
        ir = $urandom;
        if (pulseStop) stop = 1'b1;
      end else if (mPos == 4 && pulseStop) stop = 1'b0;
    end
    if (!done) checkOutput("instruction boundary timeout", 32'd0, 32'd1);
    stop = 1'b0;
  endtask

  initial begin
    logic [4:0] op;
    #1 clear = 1'b1;
    tick(1);
    checkOutput("reset all zero", dutVec, 32'h0);
    checkOutput("reset run", 32'(run), 32'd0);
    clear = 1'b0;
    tick(1);
    checkOutput("first T0", dutVec, 32'h0080_8803);

    ir = 32'h2891_8000;
    tick(3);
    checkOutput("and T3", dutVec, 32'h0020_4201);
    tick(1);
    checkOutput("and T4 alu_op", 32'(aluOp), 32'd5);
    tick(1);
    checkOutput("and T5 Gra Rin", {30'd0, gra, rIn}, 32'd3);
    checkOutput("and T5 alu_op", 32'(aluOp), 32'd0);
    tick(1);
    checkOutput("and back to T0", 32'(incPc), 32'd1);

    ir = 32'h0900_0065;
    tick(3);
    checkOutput("ldi T3", dutVec, 32'h0020_4081);
    tick(1);
    checkOutput("ldi T4", dutVec, 32'h0C00_8101);
    tick(1);
    checkOutput("ldi T5 Rin", 32'(rIn), 32'd1);
    tick(1);

    ir = 32'h0080_0000;
    tick(6);
    checkOutput("ld T6", dutVec, 32'h0100_1001);
    tick(1);
    checkOutput("ld T7", dutVec, 32'h0014_0011);
    tick(1);

    ir = 32'h1000_0000;
    tick(2);
    for (int k = 3; k <= 7; k++) begin
      tick(1);
      checkOutput("st Read low", 32'(read), 32'd0);
      checkOutput("st Write", 32'(write), (k == 7) ? 32'd1 : 32'd0);
    end
    tick(1);
    checkOutput("st back to T0", 32'(incPc), 32'd1);

    randCon = 1'b0;
    conFf   = 1'b1;
    ir      = 32'h9800_0000;
    tick(6);
    checkOutput("brx taken PCin", 32'(pcIn), 32'd1);
    tick(1);
    checkOutput("brx taken to T0", 32'(incPc), 32'd1);
    conFf = 1'b0;
    tick(6);
    checkOutput("brx not taken PCin", 32'(pcIn), 32'd0);
    tick(1);
    checkOutput("brx not taken to T0", 32'(incPc), 32'd1);
    randCon = 1'b1;

    ir = 32'h1800_0000;
    tick(4);
    checkOutput("add T4 before clear", 32'(aluOp), 32'd3);
    restart();

    ir = 32'h1800_0000;
    tick(3);
    stop = 1'b1;
    tick(2);
    checkOutput("stop add T5 Rin", {30'd0, run, rIn}, 32'd3);
    tick(1);
    checkOutput("stop add halted", 32'(run), 32'd0);
    stop = 1'b0;
    restart();

    ir = 32'hD800_0000;
    tick(3);
    for (int k = 0; k < 20; k++) begin
      checkOutput("halt run low", 32'(run), 32'd0);
      tick(1);
    end
    restart();

    for (int n = 0; n < 200; n++) begin
      op = 5'($urandom_range(0, 31));
      if (op == 5'd27 && $urandom_range(0, 3) != 0) op = 5'd26;
      applyStimulus({op, 27'($urandom)}, 1'($urandom_range(0, 19) == 0),
                    1'($urandom_range(0, 9) == 0));
      if (mMode == M_HALT) begin
        tick(3);
        restart();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
